// File: rtl/apb_pkg.sv
// Shared types and defaults for the round-robin APB master and its arbiter.
// The optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upwards (wrapping),
// so the previous winner has the lowest priority.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  // Walk from the farthest candidate to the nearest so the nearest valid one is kept.
  always_comb begin
    int c;
    c        = 0;
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[c]) begin
        grant_o    = '0;
        grant_o[c] = 1'b1;
        winner_o   = IDX_W'(c);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NUM_REQ requesters through round-robin arbitration.
// Define APB_TIMEOUT_EN to end a stalled ACCESS phase with an error after TIMEOUT_CYCLES.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSELx,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = idx_w(NUM_REQ);

  apb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic                tmo_expired;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner),
    .any_o    (any_req)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts ACCESS cycles that ended without PREADY; cleared everywhere else.
  always_comb begin
    tmo_d = '0;
    if (state_q == ACCESS && !PREADY) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (any_req) begin
          paddr_d  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(winner)*DATA_W +: DATA_W];
          pwrite_d = req_write[winner];
          owner_d  = winner;
          ptr_d    = winner;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes precedence over an expiring timeout in the same cycle.
        if (PREADY || tmo_expired) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = (PREADY && !pwrite_q) ? PRDATA : '0;
          rsp_err_d            = PREADY ? PSLVERR : 1'b1;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          state_d              = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level model checked every cycle plus
// directed scenarios with literal expectations. Honours APB_TIMEOUT_EN.
module tb_apb_rr_master;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PRDATA, PWDATA;
  logic [AW-1:0]   PADDR;
  logic            rsp_err, PSELx, PENABLE, PWRITE, PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_rr_master #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: memory, programmable wait states, error flag, stuck-not-ready mode.
  logic [31:0] smem [0:255];
  logic [7:0]  s_cnt;
  logic [7:0]  s_wait;
  logic        s_stuck, s_err;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                          s_cnt <= 8'd0;
    else if (PSELx && PENABLE && !PREADY)  s_cnt <= s_cnt + 8'd1;
    else                                   s_cnt <= 8'd0;
  end

  always @(posedge PCLK) begin
    if (PRESETn && PSELx && PENABLE && PREADY && PWRITE) smem[PADDR[7:0]] <= PWDATA;
  end

  assign PREADY  = !s_stuck && (s_cnt >= s_wait);
  assign PSLVERR = s_err;
  assign PRDATA  = PWRITE ? 32'hDEAD_BEEF : smem[PADDR[7:0]];

  // Transaction model: who wins, what is on the bus, what comes back.
  logic [31:0] mmem [0:255];
  bit          m_busy, m_pend, m_write, m_tmo;
  int          m_age, m_acc, m_last, m_own, m_pown, m_pick;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;
  logic [N-1:0] m_exp_rdy;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      m_busy = 0; m_pend = 0; m_age = 0; m_acc = 0; m_last = N - 1;
      m_rdata = '0; m_err = 1'b0;
    end else begin
      m_pick    = rr_pick(req_valid, m_last);
      m_exp_rdy = (!m_busy && m_pick >= 0) ? N'(1 << m_pick) : '0;
      chk("req_ready", 32'(req_ready), 32'(m_exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), m_pend ? (32'd1 << m_pown) : 32'd0);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("PSELx", 32'(PSELx), 32'(m_busy));
      chk("PENABLE", 32'(PENABLE), 32'(m_busy && m_age == 1));
      if (m_busy) begin
        chk("PADDR", PADDR, m_addr);
        chk("PWDATA", PWDATA, m_wdata);
        chk("PWRITE", 32'(PWRITE), 32'(m_write));
      end
      m_pend = 0;
      if (!m_busy) begin
        if (m_pick >= 0) begin
          m_busy = 1; m_age = 0; m_acc = 0; m_own = m_pick; m_last = m_pick;
          m_addr  = req_addr[m_pick*AW +: AW];
          m_wdata = req_wdata[m_pick*DW +: DW];
          m_write = req_write[m_pick];
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else begin
        m_acc++;
`ifdef APB_TIMEOUT_EN
        m_tmo = !PREADY && (m_acc >= TMO);
`else
        m_tmo = 1'b0;
`endif
        if (PREADY) begin
          m_rdata = m_write ? 32'd0 : mmem[m_addr[7:0]];
          m_err   = PSLVERR;
          if (m_write) mmem[m_addr[7:0]] = m_wdata;
          m_pend = 1; m_pown = m_own; m_busy = 0;
        end else if (m_tmo) begin
          m_rdata = 32'd0; m_err = 1'b1;
          m_pend = 1; m_pown = m_own; m_busy = 0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge PCLK); #2 PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
  endtask

  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    bit got;
    rd = 'x; er = 1'bx;
    @(posedge PCLK); #1;
    req_valid[i] = 1'b1; req_write[i] = wr;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge PCLK);
      if (req_ready[i]) got = 1;
    end
    chk($sformatf("accept_req%0d", i), 32'(got), 32'd1);
    @(posedge PCLK); #1 req_valid[i] = 1'b0;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge PCLK);
      if (rsp_valid[i]) begin got = 1; rd = rsp_rdata; er = rsp_err; end
    end
    chk($sformatf("complete_req%0d", i), 32'(got), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          gidx [5];
  int          gcyc [5];
  int          exp_ord [5] = '{0, 1, 2, 3, 0};
  int          ng, cyc, en_cnt, pulses;
  bit          got;

  initial begin
    for (int a = 0; a < 256; a++) begin smem[a] = '0; mmem[a] = '0; end
    PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    s_wait = 8'd0; s_stuck = 1'b0; s_err = 1'b0;
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b1;

    // Reset state
    @(negedge PCLK);
    chk("rst_PSELx", 32'(PSELx), 0);
    chk("rst_PENABLE", 32'(PENABLE), 0);
    chk("rst_PADDR", PADDR, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", 32'(req_ready), 0);

    // Test 1: single write from requester 0, zero wait states
    @(posedge PCLK); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0 +: AW] = 32'd5; req_wdata[0 +: DW] = 32'hA5;
    @(negedge PCLK);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    @(posedge PCLK); #1 req_valid[0] = 1'b0;
    @(negedge PCLK);
    chk("t1_c1_psel", 32'(PSELx), 1);
    chk("t1_c1_penable", 32'(PENABLE), 0);
    chk("t1_paddr", PADDR, 32'd5);
    chk("t1_pwdata", PWDATA, 32'hA5);
    chk("t1_pwrite", 32'(PWRITE), 1);
    @(negedge PCLK);
    chk("t1_c2_penable", 32'(PENABLE), 1);
    @(negedge PCLK);
    chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("t1_c3_rsp_err", 32'(rsp_err), 0);
    chk("t1_c3_psel", 32'(PSELx), 0);

    // Test 2: write then read back through the slave memory
    xfer(1, 1'b1, 32'd7, 32'h1234, rd, er);
    chk("t2_wr_rdata", rd, 0);
    chk("t2_wr_err", 32'(er), 0);
    xfer(2, 1'b0, 32'd7, 32'd0, rd, er);
    chk("t2_rd_rdata", rd, 32'h1234);
    chk("t2_rd_err", 32'(er), 0);

    // Test 3: all requesters valid continuously from a fresh reset
    do_reset();
    for (int j = 0; j < 5; j++) begin gidx[j] = -1; gcyc[j] = -100; end
    @(posedge PCLK); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_write[i] = 1'b1;
      req_addr[i*AW +: AW] = 32'(16 + i); req_wdata[i*DW +: DW] = 32'(256 + i);
    end
    ng = 0; cyc = 0;
    for (int k = 0; k < 40 && ng < 5; k++) begin
      @(negedge PCLK);
      cyc++;
      if (req_ready != '0) begin
        for (int b = 0; b < N; b++) if (req_ready[b]) gidx[ng] = b;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    @(posedge PCLK); #1 req_valid = '0;
    chk("t3_ngrants", 32'(ng), 5);
    for (int j = 0; j < 5; j++) chk($sformatf("t3_grant%0d", j), 32'(gidx[j]), 32'(exp_ord[j]));
    for (int j = 1; j < 5; j++) chk($sformatf("t3_gap%0d", j), 32'(gcyc[j] - gcyc[j-1]), 3);
    repeat (6) @(negedge PCLK);

    // Test 4: three wait states then slave error; also a read with wait states
    s_wait = 8'd3; s_err = 1'b1;
    xfer(2, 1'b1, 32'h20, 32'hCAFE, rd, er);
    chk("t4_err", 32'(er), 1);
    chk("t4_rdata", rd, 0);
    s_err = 1'b0;
    xfer(0, 1'b0, 32'd7, 32'd0, rd, er);
    chk("t4_rd_rdata", rd, 32'h1234);
    chk("t4_rd_err", 32'(er), 0);
    s_wait = 8'd0;

    // Test 5: asynchronous reset in the middle of ACCESS
    s_stuck = 1'b1;
    @(posedge PCLK); #1;
    req_valid[3] = 1'b1; req_write[3] = 1'b1; req_addr[3*AW +: AW] = 32'd9; req_wdata[3*DW +: DW] = 32'h55;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge PCLK); if (req_ready[3]) got = 1; end
    chk("t5_accept", 32'(got), 1);
    @(posedge PCLK); #1 req_valid[3] = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge PCLK); if (PENABLE) got = 1; end
    chk("t5_in_access", 32'(got), 1);
    @(posedge PCLK); #2 PRESETn = 1'b0;
    #1;
    chk("t5_PSELx", 32'(PSELx), 0);
    chk("t5_PENABLE", 32'(PENABLE), 0);
    chk("t5_PADDR", PADDR, 0);
    chk("t5_PWDATA", PWDATA, 0);
    chk("t5_PWRITE", 32'(PWRITE), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    s_stuck = 1'b0;
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_write[i] = 1'b1; req_addr[i*AW +: AW] = 32'(32 + i);
    end
    @(negedge PCLK);
    chk("t5_first_grant", 32'(req_ready), 32'b0001);
    @(posedge PCLK); #1 req_valid = '0;
    repeat (5) @(negedge PCLK);

    // Test 6: slave never ready
    s_stuck = 1'b1;
    @(posedge PCLK); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1*AW +: AW] = 32'd7;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge PCLK); if (req_ready[1]) got = 1; end
    chk("t6_accept", 32'(got), 1);
    @(posedge PCLK); #1 req_valid[1] = 1'b0;
`ifdef APB_TIMEOUT_EN
    got = 0; en_cnt = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge PCLK);
      if (PENABLE) en_cnt++;
      if (rsp_valid[1]) begin got = 1; rd = rsp_rdata; er = rsp_err; end
    end
    chk("t6_timeout_done", 32'(got), 1);
    chk("t6_access_cycles", 32'(en_cnt), 32'(TMO));
    chk("t6_err", 32'(er), 1);
    chk("t6_rdata", rd, 0);
    s_stuck = 1'b0;
`else
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (rsp_valid != '0) pulses++;
    end
    chk("t6_no_completion", 32'(pulses), 0);
    chk("t6_still_access", 32'(PENABLE), 1);
    s_stuck = 1'b0;
    do_reset();
`endif
    repeat (4) @(negedge PCLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
